// File: rtl/bitonic_pkg.sv
// Shared constants, state encoding and helpers for the bitonic network loader.
package bitonic_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 8;

    // Pad key: all ones, so padding sorts to the tail of an ascending network.
    localparam logic [DEF_WIDTH-1:0] DEF_PAD_VALUE = '1;

    typedef enum logic {
        FILL   = 1'b0,
        LAUNCH = 1'b1
    } loader_state_e;

    // Index width for an n-entry lane array (at least one bit).
    function automatic int lane_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bitonic_loader.sv
// Serial-to-frame loader feeding stage 0 of a non-stalling bitonic sorter.
// Keys arrive one per accepted handshake, fill lanes 0..N-1 in order, and the
// frame is launched with a one-cycle out_valid pulse. Unfilled lanes carry
// PAD_VALUE; out_count tells downstream how many lanes hold real keys.
//
// Handshake: a key transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high only in FILL and only while rst is deasserted. The sender
// must hold in_data/in_valid/in_last stable until the transfer happens; the
// output side has no ready because the sorting network never stalls.
module bitonic_loader
    import bitonic_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               N         = DEF_N,
    parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [N*WIDTH-1:0]     out_data,
    output logic                   out_valid,
    output logic [$clog2(N+1)-1:0] out_count
);

    localparam int PTR_W = lane_idx_w(N);
    localparam int CNT_W = $clog2(N+1);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N - 1);

    loader_state_e      state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]   lane_q [N];
    logic [WIDTH-1:0]   lane_d [N];
    logic [WIDTH-1:0]   lane_next [N];
    logic [N*WIDTH-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               accept;
    logic               launch;

    // Next-state, lane update and launch packing.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_count_d = out_count_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        launch      = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane_next[i] = lane_q[i];
            lane_d[i]    = lane_q[i];
        end

        case (state_q)
            FILL: begin
                in_ready = rst;
            end
            LAUNCH: begin
                // out_valid is high for this single cycle; resume filling.
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        accept = in_valid && in_ready;

        if (accept) begin
            lane_next[wr_ptr_q] = in_data;
            launch = in_last || (wr_ptr_q == LAST_LANE);
        end

        if (launch) begin
            // Register the frame including the key accepted on this edge,
            // then clear the buffer so the next frame starts fully padded.
            for (int i = 0; i < N; i++) begin
                out_data_d[i*WIDTH +: WIDTH] = lane_next[i];
                lane_d[i]                    = PAD_VALUE;
            end
            out_count_d = CNT_W'(wr_ptr_q) + CNT_W'(1);
            out_valid_d = 1'b1;
            wr_ptr_d    = '0;
            state_d     = LAUNCH;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                lane_d[i] = lane_next[i];
            end
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // State, lane buffer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            for (int i = 0; i < N; i++) begin
                lane_q[i] <= PAD_VALUE;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            for (int i = 0; i < N; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_bitonic_loader.sv
// Directed bench for bitonic_loader (N = 8, WIDTH = 32).
module tb_bitonic_loader;
    import bitonic_pkg::*;

    localparam int W = 32;
    localparam int N = 8;
    localparam int FW = N * W;
    localparam logic [W-1:0] P = 32'hFFFF_FFFF;

    typedef logic [W-1:0] key_t;
    typedef key_t frame_t [N];

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [FW-1:0] out_data;
    logic          out_valid;
    logic [3:0]    out_count;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;
    logic [FW-1:0] exp_q[$];
    frame_t f;

    bitonic_loader #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_count (out_count)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Count every cycle in which out_valid is high.
    always @(posedge clk) begin
        if (out_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input frame_t k);
        logic [FW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = k[i];
        return v;
    endfunction

    // Present a key and hold it until accepted; returns at the negedge after
    // the accepting edge with in_valid dropped.
    task automatic send(input logic [W-1:0] key, input logic last);
        int n;
        in_data  = key;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {{(FW-1){1'b0}}, in_ready}, {{(FW-1){1'b0}}, 1'b1});
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Called at the negedge of the launch cycle; checks it and the cycle after.
    task automatic check_launch(input string tag, input logic [3:0] cnt);
        logic [FW-1:0] exp_frame;
        exp_frame = exp_q.pop_front();
        exp_pulses++;
        chk({tag, "_out_valid"}, FW'(out_valid), FW'(1));
        chk({tag, "_in_ready_low"}, FW'(in_ready), FW'(0));
        chk({tag, "_out_data"}, out_data, exp_frame);
        chk({tag, "_out_count"}, FW'(out_count), FW'(cnt));
        @(negedge clk);
        chk({tag, "_out_valid_drop"}, FW'(out_valid), FW'(0));
        chk({tag, "_in_ready_back"}, FW'(in_ready), FW'(1));
        chk({tag, "_hold_data"}, out_data, exp_frame);
        chk({tag, "_pulses"}, FW'(pulse_cnt), FW'(exp_pulses));
    endtask

    initial begin
        rst = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", FW'(out_valid), FW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", FW'(out_count), FW'(0));
        chk("rst_in_ready", FW'(in_ready), FW'(0));
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", FW'(in_ready), FW'(1));

        // Full frame, in_valid held high.
        f = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
        exp_q.push_back(frame_of(f));
        for (int i = 0; i < N; i++) send(f[i], 1'b0);
        check_launch("full", 4'd8);

        // Short frame closed by in_last.
        send(32'd5, 1'b0);
        send(32'd5, 1'b0);
        send(32'h10, 1'b1);
        f = '{32'd5, 32'd5, 32'h10, P, P, P, P, P};
        exp_q.push_back(frame_of(f));
        check_launch("short", 4'd3);

        // Single-key frame, then a full frame with no stale keys.
        send(32'd0, 1'b1);
        f = '{32'd0, P, P, P, P, P, P, P};
        exp_q.push_back(frame_of(f));
        check_launch("single", 4'd1);
        f = '{32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 32'd26, 32'd27, 32'd28};
        exp_q.push_back(frame_of(f));
        for (int i = 0; i < N; i++) send(f[i], 1'b0);
        check_launch("after_single", 4'd8);

        // Gaps in in_valid; the next key is already valid during LAUNCH.
        f = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
        exp_q.push_back(frame_of(f));
        for (int i = 0; i < N; i++) begin
            idle($urandom_range(0, 2));
            send(f[i], 1'b0);
        end
        in_data  = 32'h200;
        in_valid = 1'b1;
        check_launch("gaps", 4'd8);
        send(32'h200, 1'b0);
        idle($urandom_range(1, 3));
        send(32'h201, 1'b0);
        send(32'h202, 1'b1);
        f = '{32'h200, 32'h201, 32'h202, P, P, P, P, P};
        exp_q.push_back(frame_of(f));
        check_launch("held_key", 4'd3);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 1'b0);
        rst = 1'b0;
        in_data = 32'hBAD;
        in_valid = 1'b1;
        #1;
        chk("midrst_in_ready", FW'(in_ready), FW'(0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("midrst_out_valid", FW'(out_valid), FW'(0));
            chk("midrst_out_data", out_data, '0);
            chk("midrst_out_count", FW'(out_count), FW'(0));
            chk("midrst_in_ready_hold", FW'(in_ready), FW'(0));
        end
        in_valid = 1'b0;
        rst = 1'b1;
        f = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36, 32'h37};
        exp_q.push_back(frame_of(f));
        for (int i = 0; i < N; i++) send(f[i], 1'b0);
        check_launch("after_rst", 4'd8);

        // in_last on the 8th key: one launch, next frame restarts at lane 0.
        f = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46, 32'h47};
        exp_q.push_back(frame_of(f));
        for (int i = 0; i < N; i++) send(f[i], (i == N - 1));
        check_launch("last8", 4'd8);
        send(32'h50, 1'b0);
        send(P, 1'b1);
        f = '{32'h50, P, P, P, P, P, P, P};
        exp_q.push_back(frame_of(f));
        check_launch("after_last8", 4'd2);

        idle(3);
        chk("final_pulses", FW'(pulse_cnt), FW'(exp_pulses));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitonic_loader.md
Name: bitonic_loader

Overview:
- Upstream feeder for the bitonic sorting network, whose compare-swap stages are registered and never stall.
- Accepts a serial stream of WIDTH-bit keys over a valid/ready handshake and assembles them into one N-lane frame.
- Pads short frames with PAD_VALUE so that padding sorts to the tail in ascending order.
- Launches each complete frame into stage 0 of the network with a single-cycle valid pulse.

Parameters:
- WIDTH, 32, key width in bits.
- N, 8, lanes per frame; a power of two, N >= 2.
- PAD_VALUE, all ones (WIDTH bits), key written into unfilled lanes; it sorts last in ascending networks.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low: reset is applied on a clk edge where rst == 0.
- in_data  input  WIDTH  incoming key.
- in_valid  input  1  in_data is valid.
- in_last  input  1  this key closes the frame; qualified by in_valid.
- in_ready  output  1  loader accepts a key this cycle.
- out_data  output  N*WIDTH  launched frame; lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle pulse; out_data holds a new frame.
- out_count  output  $clog2(N+1)  number of real (non-pad) keys in the frame, range 1..N.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = FILL, wr_ptr = 0, all lane buffers = PAD_VALUE.
  - out_data = 0, out_valid = 0, out_count = 0.
  - in_ready is forced 0 in any cycle where rst == 0.
- Reset mid-frame discards the partial frame; no out_valid is produced for it.
- States:
  - FILL: in_ready = 1.
  - LAUNCH: in_ready = 0.
- Handshake and accept rule:
  - A key is accepted when in_valid && in_ready at a clk edge; it is written to lane wr_ptr and wr_ptr increments.
  - in_valid while in_ready == 0 is ignored; upstream must hold in_data, in_valid and in_last until accepted.
- FILL -> LAUNCH on the edge that accepts either:
  - the key at wr_ptr == N-1, or
  - any key with in_last == 1.
  - When both hold, only one launch occurs.
- LAUNCH (exactly one cycle):
  - out_data is registered from the lane buffers, with the just-accepted key included.
  - out_count = number of accepted keys; out_valid = 1.
  - On the same edge: lane buffers are reset to PAD_VALUE, wr_ptr = 0, next state = FILL.
- Timing: final key accepted at edge t -> out_valid = 1 during cycle t+1 -> in_ready = 1 again from cycle t+2. Throughput is N keys per N+1 cycles.
- out_data and out_count hold their values until the next launch. out_valid is low in every cycle except the LAUNCH cycle.
- in_last on the first key of a frame gives out_count = 1, with lanes 1..N-1 = PAD_VALUE.
- Real keys equal to PAD_VALUE are legal; out_count disambiguates them from padding downstream.
- wr_ptr never exceeds N-1; there is no wrap-around within a frame.
- Arithmetic: wr_ptr is $clog2(N) bits; out_count is wr_ptr + 1, computed at $clog2(N+1) bits.

Decomposition:
- Shared package bitonic_pkg holds:
  - default WIDTH and N constants;
  - PAD_VALUE constant;
  - state enum { FILL, LAUNCH };
  - a lane-index width function (clog2).
- The block is a single module. No sub-module is warranted; the lane buffer is an N-entry register array inside it.

Test Plan (N = 8, WIDTH = 32 unless stated):
- Full frame: stream 7, 3, 9, 1, 8, 2, 6, 4 with in_valid held high -> out_valid pulses once, one cycle after the 8th accept. out_data lanes 0..7 = 7, 3, 9, 1, 8, 2, 6, 4; out_count = 8. in_ready is low for exactly that cycle.
- Short frame: keys 5, 5, 0x10 with in_last on 0x10 -> lanes = 5, 5, 0x10, then FFFFFFFF x5; out_count = 3.
- Single-key frame: key 0 with in_last -> lane 0 = 0, lanes 1..7 = FFFFFFFF, out_count = 1. A following full frame has no stale keys from this frame.
- Backpressure and gaps: in_valid toggles randomly, and in_valid is asserted during the LAUNCH cycle -> no key is lost or duplicated. The held key is accepted on the first FILL cycle. Frames compare equal to the model.
- Reset mid-frame: accept 4 keys, then drive rst = 0 for 2 cycles -> no out_valid, out_data = 0, out_count = 0, in_ready = 0 during reset. The next 8 keys form a clean frame with no residue from the discarded keys.
- in_last coincident with the 8th key -> exactly one out_valid; out_count = 8; the next frame starts at lane 0.
